// File: rtl/fm_pkg.sv
// Shared types and constants for the FM modulator: FSM state encoding,
// dither LFSR seed/taps and the quarter-wave sine table generator.
package fm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FADE  = 2'd2,
    MUTED = 2'd3
  } fm_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Quarter-wave entry idx of a 2^m-entry cycle, sampled at half-step offsets,
  // rounded to d-1 magnitude bits. Integer Bhaskara approximation of sin.
  function automatic int sine_q(input int idx, input int m, input int d);
    int dd;
    int n;
    int p;
    int num;
    int den;
    int s;
    dd  = 4 * (2 ** (m - 2));
    n   = 2 * idx + 1;
    p   = n * (dd - n);
    num = 16 * p;
    den = 5 * dd * dd - 4 * p;
    s   = (2 ** (d - 1)) - 1;
    return (2 * s * num + den) / (2 * den);
  endfunction

endpackage

// File: rtl/fm_sine_lut.sv
// Registered quarter-wave sine lookup: M-bit phase in, D-bit offset-binary out.
// Quadrants 1/3 mirror the index; quadrants 2/3 fold the sign.
module fm_sine_lut
  import fm_pkg::*;
#(
  parameter int M = 5,
  parameter int D = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [M-1:0] phase_i,
  output logic [D-1:0] rf_o
);

  localparam int Q = 2 ** (M - 2);

  logic [D-2:0] tab_s [Q];

  for (genvar g = 0; g < Q; g++) begin : g_tab
    localparam int V = sine_q(g, M, D);
    assign tab_s[g] = V[D-2:0];
  end

  logic [M-3:0] idx_s;
  logic [D-2:0] mag_s;
  logic [D-1:0] rf_d;
  logic [D-1:0] rf_q;

  always_comb begin
    if (phase_i[M-2]) begin
      idx_s = ~phase_i[M-3:0];
    end else begin
      idx_s = phase_i[M-3:0];
    end
    mag_s = tab_s[idx_s];
    if (phase_i[M-1]) begin
      rf_d = {1'b0, ~mag_s};
    end else begin
      rf_d = {1'b1, mag_s};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_q <= {1'b1, {(D-1){1'b0}}};
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rf_o = rf_q;

endmodule

// File: rtl/fm_mod_interp.sv
// FM modulator: interpolated audio -> deviation -> dithered phase accumulator -> sine DAC word.
// Optional pre-emphasis on accepted samples with FM_PREEMPH_EN.
module fm_mod_interp
  import fm_pkg::*;
#(
  parameter int A = 8,
  parameter int L = 12,
  parameter int N = 18,
  parameter int M = 5,
  parameter int D = 4,
  parameter int K = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                audio_valid,
  input  logic signed [A-1:0] audio,
  output logic                audio_ready,
  input  logic [N-1:0]        acc_inc,
  input  logic [L-1:0]        df_inc,
  input  logic [2:0]          dith_fact,
  input  logic                mute,
  output logic [D-1:0]        rf,
  output logic                active
);

  localparam logic [K:0] RAMP_LEN = {1'b1, {K{1'b0}}};
  localparam logic [K:0] RAMP_ONE = (K+1)'(1);

  fm_state_e              state_q, state_d;
  logic                   ready_q, active_q;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [N-1:0]           phase_q, phase_d;
  logic signed [A+K:0]    cur_fx_q, cur_fx_d;
  logic signed [A:0]      delta_q, delta_d;
  logic [K:0]             cnt_q, cnt_d;
  logic signed [A-1:0]    samp_q, samp_d;

  logic                   accept_s;
  logic signed [A-1:0]    new_s;
  logic signed [A:0]      cur_s;
  logic signed [A:0]      tgt_s;
  logic                   retgt_s;
  logic signed [A+L+1:0]  prod_s;
  logic signed [A+L+1:0]  sh_s;
  logic [N-1:0]           dev_s;
  logic [N-1:0]           inc_s;
  logic [N-M-1:0]         dith_s;
  logic [M-1:0]           lut_phase_s;

  assign accept_s = audio_valid & ready_q;
  assign cur_s    = cur_fx_q[A+K:K];

`ifdef FM_PREEMPH_EN
  localparam logic signed [A+2:0] EMPH_MAX = (A+3)'((2 ** (A - 1)) - 1);
  localparam logic signed [A+2:0] EMPH_MIN = (A+3)'(-(2 ** (A - 1)));

  logic signed [A-1:0] xprev_q, xprev_d;
  logic signed [A+2:0] x_s, xp_s, emph_s;

  always_comb begin
    x_s    = {{3{audio[A-1]}}, audio};
    xp_s   = {{3{xprev_q[A-1]}}, xprev_q};
    emph_s = x_s + ((x_s - xp_s) <<< 1);
    if (emph_s > EMPH_MAX) begin
      new_s = EMPH_MAX[A-1:0];
    end else if (emph_s < EMPH_MIN) begin
      new_s = EMPH_MIN[A-1:0];
    end else begin
      new_s = emph_s[A-1:0];
    end
    if (accept_s) begin
      xprev_d = audio;
    end else begin
      xprev_d = xprev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xprev_q <= '0;
    end else begin
      xprev_q <= xprev_d;
    end
  end
`else
  assign new_s = audio;
`endif

  // Mute FSM and interpolator: every retarget restarts a 2^K-step ramp from the current integer value
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    retgt_s  = 1'b0;
    tgt_s    = '0;
    cur_fx_d = cur_fx_q;
    delta_d  = delta_q;
    cnt_d    = cnt_q;
    if (accept_s) begin
      samp_d = new_s;
    end else begin
      samp_d = samp_q;
    end
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (mute) begin
          state_d = FADE;
          retgt_s = 1'b1;
        end else if (accept_s) begin
          retgt_s = 1'b1;
          tgt_s   = {new_s[A-1], new_s};
        end else begin
          state_d = RUN;
        end
      end
      FADE: begin
        if (!mute) begin
          state_d = RUN;
          retgt_s = 1'b1;
          tgt_s   = {samp_q[A-1], samp_q};
        end else if (cnt_q <= RAMP_ONE) begin
          state_d = MUTED;
        end else begin
          state_d = FADE;
        end
      end
      MUTED: begin
        if (!mute) begin
          state_d = RUN;
          retgt_s = 1'b1;
          tgt_s   = accept_s ? {new_s[A-1], new_s} : {samp_q[A-1], samp_q};
        end else begin
          state_d = MUTED;
        end
      end
      default: state_d = IDLE;
    endcase
    if (retgt_s) begin
      cur_fx_d = {cur_s, {K{1'b0}}};
      delta_d  = tgt_s - cur_s;
      cnt_d    = RAMP_LEN;
    end else if (cnt_q != '0) begin
      cur_fx_d = cur_fx_q + {{K{delta_q[A]}}, delta_q};
      cnt_d    = cnt_q - RAMP_ONE;
    end else begin
      cur_fx_d = cur_fx_q;
    end
  end

  always_comb begin
    prod_s  = cur_s * $signed({1'b0, df_inc});
    sh_s    = prod_s >>> (A - 1);
    dev_s   = N'(sh_s);
    inc_s   = acc_inc + dev_s;
    phase_d = phase_q + inc_s;
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    if (dith_fact != 3'd0) begin
      dith_s = lfsr_q[N-M-1:0] >> (3'd7 - dith_fact);
    end else begin
      dith_s = '0;
    end
    lut_phase_s = M'((phase_q + {{M{1'b0}}, dith_s}) >> (N - M));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      phase_q  <= '0;
      cur_fx_q <= '0;
      delta_q  <= '0;
      cnt_q    <= '0;
      samp_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == RUN) || (state_d == MUTED);
      active_q <= (state_d == RUN);
      lfsr_q   <= lfsr_d;
      phase_q  <= phase_d;
      cur_fx_q <= cur_fx_d;
      delta_q  <= delta_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
    end
  end

  fm_sine_lut #(.M(M), .D(D)) u_lut (
    .clk_i   (clk),
    .rst_i   (rst),
    .phase_i (lut_phase_s),
    .rf_o    (rf)
  );

  assign audio_ready = ready_q;
  assign active      = active_q;

endmodule
